// File: rtl/posit_normalize_prod_pipe.sv
// Three-stage posit normaliser/rounder for a multiplier product (sign, scale, fraction).
// Define POSIT_NORM_SATURATE_EN to clamp out-of-range scales to maxpos/minpos instead of NaR/zero.
module posit_normalize_prod_pipe #(
  parameter int NBITS   = 32,
  parameter int ES      = 3,
  parameter int SCALE_W = 10,
  parameter int FRAC_W  = 54
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sgn,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [FRAC_W-1:0]  in_fraction,
  input  logic               in_truncated,
  input  logic               in_inf,
  input  logic               in_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NBITS-1:0]   out_result,
  output logic               out_inf,
  output logic               out_zero
);

  localparam int MW = NBITS - 1;
  localparam int XW = 2 + ES + FRAC_W + NBITS;
  localparam logic signed [SCALE_W-1:0] MAX_SCALE = SCALE_W'((2**ES) * (NBITS - 2));
  localparam logic signed [SCALE_W-1:0] MIN_SCALE = -MAX_SCALE;

  function automatic logic [MW-1:0] round_rne(input logic [MW-1:0] mag, input logic guard,
                                              input logic sticky);
    logic [MW:0] sum;
    sum = {1'b0, mag} + (MW+1)'(guard & (sticky | mag[0]));
    if (sum[MW]) return {MW{1'b1}};
    if (sum[MW-1:0] == '0) return MW'(1);
    return sum[MW-1:0];
  endfunction

  function automatic logic [NBITS-1:0] apply_sign(input logic sgn, input logic [MW-1:0] mag);
    logic [NBITS-1:0] v;
    v = {1'b0, mag};
    return sgn ? (~v + NBITS'(1)) : v;
  endfunction

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic ld1, ld2, ld3;

  assign ld3       = ~vld_p3_q | out_ready;
  assign ld2       = ~vld_p2_q | ld3;
  assign ld1       = ~vld_p1_q | ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_p3_q;

  // ---- S1: regime/exponent split and range flags
  logic signed [SCALE_W-1:0] scale_s, k_d;
  logic                      ovf_d, unf_d;
  logic signed [SCALE_W-1:0] k_p1_q;
  logic [ES-1:0]             e_p1_q;
  logic [FRAC_W-1:0]         frac_p1_q;
  logic                      sgn_p1_q, trunc_p1_q, inf_p1_q, zero_p1_q, ovf_p1_q, unf_p1_q;

  assign scale_s = $signed(in_scale);
  assign k_d     = scale_s >>> ES;
  assign ovf_d   = scale_s > MAX_SCALE;
  assign unf_d   = scale_s < MIN_SCALE;

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      sgn_p1_q   <= in_sgn;
      k_p1_q     <= k_d;
      e_p1_q     <= in_scale[ES-1:0];
      frac_p1_q  <= in_fraction;
      trunc_p1_q <= in_truncated;
      inf_p1_q   <= in_inf;
      zero_p1_q  <= in_zero;
      ovf_p1_q   <= ovf_d;
      unf_p1_q   <= unf_d;
    end
  end

  // ---- S2: regime shift, guard/sticky, round to nearest even
  logic [SCALE_W-1:0]    sh;
  logic signed [XW-1:0]  x, xs;
  logic [MW-1:0]         mag_d, mag_p2_q;
  logic                  guard, sticky;
  logic                  sgn_p2_q, inf_p2_q, zero_p2_q, ovf_p2_q, unf_p2_q;

  always_comb begin
    // Leading {1,0} sign-extended by k gives k+1 ones then 0; {0,1} shifted by -k-1 gives -k zeros then 1.
    sh     = k_p1_q[SCALE_W-1] ? ~k_p1_q : k_p1_q;
    x      = {~k_p1_q[SCALE_W-1], k_p1_q[SCALE_W-1], e_p1_q, frac_p1_q, {NBITS{1'b0}}};
    xs     = x >>> sh;
    guard  = xs[XW-MW-1];
    sticky = (|xs[XW-MW-2:0]) | trunc_p1_q;
    mag_d  = round_rne(xs[XW-1 -: MW], guard, sticky);
  end

  always_ff @(posedge clk) begin
    if (ld2 && vld_p1_q) begin
      sgn_p2_q  <= sgn_p1_q;
      mag_p2_q  <= mag_d;
      inf_p2_q  <= inf_p1_q;
      zero_p2_q <= zero_p1_q;
      ovf_p2_q  <= ovf_p1_q;
      unf_p2_q  <= unf_p1_q;
    end
  end

  // ---- S3: specials, range handling, sign
  logic [NBITS-1:0] res_d, res_q;
  logic             oinf_d, ozero_d, oinf_q, ozero_q;

  always_comb begin
    res_d   = apply_sign(sgn_p2_q, mag_p2_q);
    oinf_d  = 1'b0;
    ozero_d = 1'b0;
    if (inf_p2_q) begin
      res_d  = {1'b1, {MW{1'b0}}};
      oinf_d = 1'b1;
    end else if (zero_p2_q) begin
      res_d   = '0;
      ozero_d = 1'b1;
    end else if (ovf_p2_q) begin
`ifdef POSIT_NORM_SATURATE_EN
      res_d  = apply_sign(sgn_p2_q, {MW{1'b1}});
`else
      res_d  = {1'b1, {MW{1'b0}}};
      oinf_d = 1'b1;
`endif
    end else if (unf_p2_q) begin
`ifdef POSIT_NORM_SATURATE_EN
      res_d   = apply_sign(sgn_p2_q, MW'(1));
`else
      res_d   = '0;
      ozero_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      res_q    <= '0;
      oinf_q   <= 1'b0;
      ozero_q  <= 1'b0;
    end else begin
      if (ld1) vld_p1_q <= in_valid;
      if (ld2) vld_p2_q <= vld_p1_q;
      if (ld3) vld_p3_q <= vld_p2_q;
      if (ld3 && vld_p2_q) begin
        res_q   <= res_d;
        oinf_q  <= oinf_d;
        ozero_q <= ozero_d;
      end
    end
  end

  assign out_result = res_q;
  assign out_inf    = oinf_q;
  assign out_zero   = ozero_q;

endmodule

// File: tb/tb_posit_normalize_prod_pipe.sv
// Directed bench for posit_normalize_prod_pipe (NBITS=32, ES=3); honours POSIT_NORM_SATURATE_EN.
module tb_posit_normalize_prod_pipe;
  localparam int NBITS = 32, ES = 3, SCALE_W = 10, FRAC_W = 54;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               in_valid = 1'b0, in_ready;
  logic               in_sgn = 1'b0;
  logic [SCALE_W-1:0] in_scale = '0;
  logic [FRAC_W-1:0]  in_fraction = '0;
  logic               in_truncated = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
  logic               out_valid, out_ready = 1'b0;
  logic [NBITS-1:0]   out_result;
  logic               out_inf, out_zero;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  posit_normalize_prod_pipe #(.NBITS(NBITS), .ES(ES), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sgn(in_sgn),
    .in_scale(in_scale), .in_fraction(in_fraction), .in_truncated(in_truncated), .in_inf(in_inf),
    .in_zero(in_zero), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_inf(out_inf), .out_zero(out_zero));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sgn, input int sc, input logic [FRAC_W-1:0] fr,
                       input logic tr, input logic inf, input logic zero);
    in_sgn       = sgn;
    in_scale     = SCALE_W'(sc);
    in_fraction  = fr;
    in_truncated = tr;
    in_inf       = inf;
    in_zero      = zero;
  endtask

  // Called #1 after a rising edge with an empty pipeline.
  task automatic run_vec(input string tag, input logic sgn, input int sc, input logic [FRAC_W-1:0] fr,
                         input logic tr, input logic inf, input logic zero,
                         input logic [NBITS-1:0] eres, input logic einf, input logic ezero);
    drive(sgn, sc, fr, tr, inf, zero);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_res"}, out_result, eres);
    check({tag, "_inf"}, out_inf, einf);
    check({tag, "_zero"}, out_zero, ezero);
  endtask

  int                bp_sc  [10] = '{0, 1, 8, -8, 7, 16, -16, -1, 240, -240};
  logic              bp_sg  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [NBITS-1:0]  bp_exp [10] = '{32'h40000000, 32'h44000000, 32'h60000000, 32'h20000000,
                                     32'hA4000000, 32'h70000000, 32'h10000000, 32'h3C000000,
                                     32'h7FFFFFFF, 32'h00000001};

  initial begin
    logic [FRAC_W-1:0] f_guard, f_tie_odd, f_ones, f_msb;
    int                ii, oc, cyc;
    logic              stalled;
    logic [NBITS-1:0]  held;
    f_guard   = FRAC_W'(1) << 27;
    f_tie_odd = (FRAC_W'(1) << 27) | (FRAC_W'(1) << 28);
    f_ones    = '1;
    f_msb     = FRAC_W'(1) << (FRAC_W - 1);

    #12;
    check("rst_vld", out_valid, 1'b0);
    check("rst_rdy", in_ready, 1'b1);
    check("rst_res", out_result, 32'h0);
    check("rst_flags", {out_inf, out_zero}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_vec("one",     1'b0, 0,    '0,        1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_vec("negone",  1'b1, 0,    '0,        1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0);
    run_vec("negreg",  1'b0, -1,   '0,        1'b0, 1'b0, 1'b0, 32'h3C000000, 1'b0, 1'b0);
    run_vec("tie_even",1'b0, 0,    f_guard,   1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_vec("tie_stk", 1'b0, 0,    f_guard,   1'b1, 1'b0, 1'b0, 32'h40000001, 1'b0, 1'b0);
    run_vec("tie_odd", 1'b0, 0,    f_tie_odd, 1'b0, 1'b0, 1'b0, 32'h40000002, 1'b0, 1'b0);
    run_vec("carry_e", 1'b0, 7,    f_ones,    1'b0, 1'b0, 1'b0, 32'h60000000, 1'b0, 1'b0);
    run_vec("frac_n",  1'b1, 0,    f_msb,     1'b0, 1'b0, 1'b0, 32'hBE000000, 1'b0, 1'b0);
    run_vec("rnd_max", 1'b0, 239,  '0,        1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_vec("maxpos",  1'b0, 240,  '0,        1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_vec("minpos",  1'b0, -240, '0,        1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    run_vec("nar",     1'b0, 0,    '0,        1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0);
    run_vec("zero",    1'b1, 5,    '0,        1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
`ifdef POSIT_NORM_SATURATE_EN
    run_vec("ovf",     1'b0, 300,  '0,        1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_vec("ovf_n",   1'b1, 241,  '0,        1'b0, 1'b0, 1'b0, 32'h80000001, 1'b0, 1'b0);
    run_vec("unf",     1'b0, -300, '0,        1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    run_vec("unf_n",   1'b1, -241, '0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
`else
    run_vec("ovf",     1'b0, 300,  '0,        1'b0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0);
    run_vec("ovf_n",   1'b1, 241,  '0,        1'b0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0);
    run_vec("unf",     1'b0, -300, '0,        1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1);
    run_vec("unf_n",   1'b1, -241, '0,        1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1);
`endif

    @(posedge clk); #1;
    ii = 0; oc = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (oc < 10 && cyc < 400) begin
      if (stalled) begin
        check("bp_hold_vld", out_valid, 1'b1);
        check("bp_hold_res", out_result, held);
      end
      in_valid = (ii < 10);
      if (ii < 10) drive(bp_sg[ii], bp_sc[ii], '0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", oc), out_result, bp_exp[oc]);
        oc++;
      end
      stalled = out_valid && !out_ready;
      held    = out_result;
      if (in_valid && in_ready) ii++;
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_count", oc, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drain", out_valid, 1'b0);

    out_ready = 1'b0;
    drive(1'b0, 8, '0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_pre_vld", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 1'b0);
    check("mid_rst_rdy", in_ready, 1'b1);
    check("mid_rst_res", out_result, 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec("post_rst", 1'b0, -8, '0, 1'b0, 1'b0, 1'b0, 32'h20000000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_drain", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
